// File: rtl/op_sequencer.sv
// op_sequencer: fetches func/value pairs from an external command memory,
// executes them on an accumulator/load-register pair, and strobes a display
// value or an end-of-program flag.
// Optional feature: define OP_SEQUENCER_STEP_EN for single-step mode (step
// port plus HOLD state between instructions).
module op_sequencer #(
   parameter int unsigned DW       = 8,
   parameter int unsigned LAST_SEL = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
`ifdef OP_SEQUENCER_STEP_EN
   input  logic          step,
`endif
   input  logic [4:0]    func,
   input  logic [4:0]    value,
   output logic [4:0]    selector,
   output logic          busy,
   output logic          disp_valid,
   output logic [DW-1:0] disp_data,
   output logic          done,
   output logic          err
);

   localparam int unsigned SW = 5;
   localparam logic [SW-1:0] LAST      = SW'(LAST_SEL);
   localparam logic [4:0]    F_CLEARLD = 5'd0;
   localparam logic [4:0]    F_ADDLD   = 5'd1;
   localparam logic [4:0]    F_ADD     = 5'd2;
   localparam logic [4:0]    F_SHTR    = 5'd3;
   localparam logic [4:0]    F_DISP    = 5'd4;

`ifdef OP_SEQUENCER_STEP_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HOLD, S_DONE} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;
`endif

   state_e        state_q, state_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [DW-1:0] acc_q, acc_d;
   logic [DW-1:0] ld_q, ld_d;
   logic [4:0]    ir_func_q, ir_func_d;
   logic [4:0]    ir_val_q, ir_val_d;
   logic [DW-1:0] disp_q, disp_d;
   logic          dv_q, dv_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic [DW-1:0] val_ext;

   assign val_ext = DW'(ir_val_q);

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         acc_q     <= '0;
         ld_q      <= '0;
         ir_func_q <= '0;
         ir_val_q  <= '0;
         disp_q    <= '0;
         dv_q      <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         acc_q     <= acc_d;
         ld_q      <= ld_d;
         ir_func_q <= ir_func_d;
         ir_val_q  <= ir_val_d;
         disp_q    <= disp_d;
         dv_q      <= dv_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   // Next-state, instruction execution and registered-output decode
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      acc_d     = acc_q;
      ld_d      = ld_q;
      ir_func_d = ir_func_q;
      ir_val_d  = ir_val_q;
      disp_d    = disp_q;
      dv_d      = 1'b0;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d   = '0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_func_d = func;
            ir_val_d  = value;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            case (ir_func_q)
               F_CLEARLD: begin
                  acc_d = '0;
                  ld_d  = val_ext;
               end
               F_ADDLD: begin
                  acc_d = acc_q + val_ext;
                  ld_d  = val_ext;
               end
               F_ADD:  acc_d = acc_q + ld_q;
               F_SHTR: acc_d = acc_q >> 1;
               F_DISP: begin
                  disp_d  = acc_q;
                  dv_d    = 1'b1;
                  state_d = S_DONE;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            endcase
            // Non-terminal instructions advance, or finish at the last selector
            if (ir_func_q <= F_SHTR) begin
               if (sel_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  sel_d   = sel_q + SW'(1);
`ifdef OP_SEQUENCER_STEP_EN
                  state_d = S_HOLD;
`else
                  state_d = S_FETCH;
`endif
               end
            end
         end
`ifdef OP_SEQUENCER_STEP_EN
         S_HOLD: begin
            if (step) state_d = S_FETCH;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_FETCH) || (state_d == S_EXEC)
`ifdef OP_SEQUENCER_STEP_EN
               || (state_d == S_HOLD)
`endif
               ;
   end

   assign selector   = sel_q;
   assign busy       = busy_q;
   assign disp_valid = dv_q;
   assign disp_data  = disp_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
